ama_riscv_icache: RTL and testbench
===================================

// Module: ama_riscv_icache
// PURPOSE
// - Direct-mapped, read-only instruction cache between core fetch and the unified memory imem port.
// - Core issues 32-bit byte addresses and gets 32-bit instructions back.
// - Misses fetch one full 128-bit line from memory with a line-indexed read, then return the critical word.
// - Provides fence.i flush and hit/miss counters for perf reporting.
// PARAMETERS
// - SETS        16   number of lines, power of 2 >= 2; IDX_W = $clog2(SETS)
// - LINE_W      128  line width in bits, equal to memory data bus; 4 words per line
// - MEM_ADDR_W  14   memory line-address width
// PORTS
// - clk            in   1           clock
// - rst            in   1           reset; asynchronous, active-high
// - cpu_req_valid  in   1           fetch request valid
// - cpu_req_ready  out  1           cache can accept a request this cycle
// - cpu_req_addr   in   32          fetch byte address; [1:0] must be 0
// - cpu_rsp_valid  out  1           instruction valid, single-cycle pulse, no backpressure
// - cpu_rsp_data   out  32          instruction word
// - flush          in   1           fence.i: invalidate all lines
// - mem_req_valid  out  1           line-fill request valid
// - mem_req_ready  in   1           memory accepts request
// - mem_req_addr   out  MEM_ADDR_W  line address = cpu_req_addr[4+MEM_ADDR_W-1:4]
// - mem_rsp_valid  in   1           line data valid, single-cycle pulse
// - mem_rsp_data   in   LINE_W      line data; word w at bits [32*w+31:32*w]
// - hit_cnt        out  32          accepted requests that hit
// - miss_cnt       out  32          accepted requests that missed
// BEHAVIOUR
// - Address split:
//   - word = addr[3:2]
//   - index = addr[4+IDX_W-1:4]
//   - tag = addr[31:4+IDX_W]
// - Storage: per set, a valid bit, a tag and the line.
//   - Only valid bits are reset. Tag and data are not reset.
// - Reset values:
//   - state = RUN; all valid = 0; flush_pend = 0
//   - cpu_rsp_valid = 0, cpu_rsp_data = 0
//   - mem_req_valid = 0, mem_req_addr = 0
//   - hit_cnt = miss_cnt = 0
// - FSM states: RUN, MISS_REQ, MISS_WAIT.
// - cpu_req_ready = (state==RUN) && !flush && !flush_pend.
// - Accept = cpu_req_valid && cpu_req_ready. On accept, the request address is registered and the tag is compared combinationally in the same cycle.
// - RUN, accept, hit:
//   - cpu_rsp_valid=1 next cycle with the selected word; hit_cnt++.
//   - Stays in RUN, so back-to-back hits give 1 instruction per cycle.
// - RUN, accept, miss:
//   - miss_cnt++; next state MISS_REQ.
//   - mem_req_valid=1 and mem_req_addr are registered for the next cycle.
// - MISS_REQ:
//   - Hold mem_req_valid and mem_req_addr stable until mem_req_ready.
//   - On handshake: mem_req_valid=0 next cycle; go to MISS_WAIT.
// - MISS_WAIT, on mem_rsp_valid:
//   - Write line, tag and valid=1 at the stored index.
//   - cpu_rsp_valid=1 next cycle; cpu_rsp_data is the requested word taken directly from mem_rsp_data.
//   - Return to RUN.
// - Miss latency with a 1-cycle memory and mem_req_ready=1:
//   - accept at N, mem_req at N+1, mem_rsp at N+2, cpu_rsp at N+3, ready again at N+3.
// - cpu_rsp_valid is high exactly one cycle per accepted request.
//   - cpu_rsp_data holds its value when cpu_rsp_valid=0.
// - mem_rsp_valid outside MISS_WAIT is ignored.
//   - This covers stale responses after reset mid-miss.
// - Flush:
//   - In RUN, flush clears all valid bits next cycle; no request is accepted that cycle.
//   - In MISS_REQ/MISS_WAIT, flush sets flush_pend. The miss completes normally and its response is delivered.
//   - On return to RUN, pending flush clears all valid bits, including the just-filled line, in one cycle; flush_pend=0 and ready resumes next cycle.
// - Reset mid-miss: state and valid bits cleared immediately; the outstanding core request is dropped; mem_req_valid=0.
// - Counters wrap modulo 2^32; no saturation.
// - Non-word-aligned addresses are illegal; the sim-only assertion fires on accept with addr[1:0]!=0.
// TESTING
// - Cold fetch 0x0000_0100 (mem line 0x10 = 128'h4444..._3333..._2222..._1111...) -> mem_req_addr=0x10 at N+1; cpu_rsp_data=32'h1111_1111 at N+3; miss_cnt=1.
// - Then fetch 0x104, 0x108, 0x10C back-to-back -> 3 consecutive cpu_rsp_valid cycles with 2222.., 3333.., 4444..; no mem_req; hit_cnt=3.
// - Conflict: fetch 0x100 then 0x100+16*SETS (same index) -> second fetch misses; fetching 0x100 again misses again; miss_cnt=3.
// - mem_req_ready held low 5 cycles in MISS_REQ -> mem_req_valid/addr stable all 5 cycles; cpu_req_ready=0 throughout; single fill.
// - Flush during MISS_WAIT on 0x200 -> response still delivered; the next 0x200 fetch misses.
// - Flush in RUN with cpu_req_valid=1 -> request not accepted that cycle; accepted next cycle as a miss.
// - Reset asserted during MISS_WAIT, then mem_rsp_valid pulses after reset release -> no cpu_rsp_valid; counters 0; all lines invalid.

Source files
------------

// File: rtl/ama_riscv_icache_if.sv
// Core-fetch and memory line-fill signals of the instruction cache, bundled.
// The cache connects through the slave modport; the fetch/memory side uses master.
interface ama_riscv_icache_if #(
    parameter int LINE_W     = 128,
    parameter int MEM_ADDR_W = 14
);
    logic                  cpu_req_valid;
    logic                  cpu_req_ready;
    logic [31:0]           cpu_req_addr;
    logic                  cpu_rsp_valid;
    logic [31:0]           cpu_rsp_data;
    logic                  flush;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [MEM_ADDR_W-1:0] mem_req_addr;
    logic                  mem_rsp_valid;
    logic [LINE_W-1:0]     mem_rsp_data;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    modport slave (
        input  cpu_req_valid, cpu_req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_req_addr,
               hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_data, mem_req_valid, mem_req_addr,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/ama_riscv_icache.sv
// Direct-mapped read-only instruction cache with single-line fill, fence.i flush and hit/miss counters.
// Latency: hit 1 cycle; miss 3 cycles with a 1-cycle memory (request, response, critical-word return).
// Backpressure: cpu_req_ready low during a miss or flush; mem request held until mem_req_ready; no rsp backpressure.
module ama_riscv_icache #(
    parameter int SETS       = 16,
    parameter int LINE_W     = 128,
    parameter int MEM_ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    ama_riscv_icache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 4 - IDX_W;

    typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_arr  [SETS];
    logic [LINE_W-1:0] data_arr [SETS];
    logic              flush_pend;

    logic [1:0]        req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;

    logic [1:0]        in_word;
    logic [IDX_W-1:0]  in_idx;
    logic [TAG_W-1:0]  in_tag;
    logic              accept;
    logic              hit;
    logic [LINE_W-1:0] hit_line;
    logic              fill;

    assign in_word  = bus.cpu_req_addr[3:2];
    assign in_idx   = bus.cpu_req_addr[4 +: IDX_W];
    assign in_tag   = bus.cpu_req_addr[31 -: TAG_W];

    assign bus.cpu_req_ready = (state == RUN) && !bus.flush && !flush_pend;
    assign accept   = bus.cpu_req_valid && bus.cpu_req_ready;
    assign hit      = valid[in_idx] && (tag_arr[in_idx] == in_tag);
    assign hit_line = data_arr[in_idx];
    // Responses arriving in any other state (e.g. stale after reset) are ignored.
    assign fill     = (state == MISS_WAIT) && bus.mem_rsp_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:       if (accept && !hit)    state_nxt = MISS_REQ;
            MISS_REQ:  if (bus.mem_req_ready) state_nxt = MISS_WAIT;
            MISS_WAIT: if (bus.mem_rsp_valid) state_nxt = RUN;
            default:                          state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid             <= '0;
            flush_pend        <= 1'b0;
            req_word          <= '0;
            req_idx           <= '0;
            req_tag           <= '0;
            bus.cpu_rsp_valid <= 1'b0;
            bus.cpu_rsp_data  <= '0;
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_addr  <= '0;
            bus.hit_cnt       <= '0;
            bus.miss_cnt      <= '0;
        end else begin
            bus.cpu_rsp_valid <= 1'b0;
            if (accept) begin
                req_word <= in_word;
                req_idx  <= in_idx;
                req_tag  <= in_tag;
                if (hit) begin
                    bus.cpu_rsp_valid <= 1'b1;
                    bus.cpu_rsp_data  <= hit_line[{in_word, 5'b0} +: 32];
                    bus.hit_cnt       <= bus.hit_cnt + 32'd1;
                end else begin
                    bus.miss_cnt      <= bus.miss_cnt + 32'd1;
                    bus.mem_req_valid <= 1'b1;
                    bus.mem_req_addr  <= bus.cpu_req_addr[4 +: MEM_ADDR_W];
                end
            end
            if (state == MISS_REQ && bus.mem_req_ready)
                bus.mem_req_valid <= 1'b0;
            if (fill) begin
                valid[req_idx]    <= 1'b1;
                bus.cpu_rsp_valid <= 1'b1;
                bus.cpu_rsp_data  <= bus.mem_rsp_data[{req_word, 5'b0} +: 32];
            end
            // A flush seen mid-miss waits until the fill is delivered, then wipes that line too.
            if (state == RUN && (bus.flush || flush_pend)) begin
                valid      <= '0;
                flush_pend <= 1'b0;
            end else if (state != RUN && bus.flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= bus.mem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    a_word_aligned: assert property (@(posedge clk) disable iff (rst)
        accept |-> (bus.cpu_req_addr[1:0] == 2'b00));
`endif

endmodule

// File: tb/tb_ama_riscv_icache.sv
// Bench for ama_riscv_icache: directed vector table, hand-written miss/flush/reset sequences,
// and random fetch/flush/stall traffic checked against an abstract cache model.
module tb_ama_riscv_icache;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ama_riscv_icache_if bus ();
    ama_riscv_icache dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    bit mem_auto;
    bit acc_last, flush_last;
    int fills;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[6];

    bit          m_valid [16];
    logic [27:0] m_line  [16];
    bit          outstanding, pend, gate;
    logic [31:0] exp_miss;
    int          m_hits, m_misses, wait_cnt;

    function automatic logic [127:0] line_of(input logic [13:0] la);
        logic [127:0] l;
        if (la == 14'h10)
            l = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        else
            for (int w = 0; w < 4; w++) l[32*w +: 32] = {la, 2'(w), 16'hBEEF};
        return l;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        logic [127:0] l;
        l = line_of(addr[17:4]);
        return l[32*int'(addr[3:2]) +: 32];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: capture handshakes just before the edge, then act as a 1-cycle memory.
    task automatic cyc();
        bit          hs;
        logic [13:0] a;
        #3;
        hs         = bus.mem_req_valid && bus.mem_req_ready;
        a          = bus.mem_req_addr;
        acc_last   = bus.cpu_req_valid && bus.cpu_req_ready;
        flush_last = bus.flush;
        @(posedge clk);
        #1;
        if (hs) fills++;
        if (mem_auto) begin
            bus.mem_rsp_valid = hs;
            bus.mem_rsp_data  = hs ? line_of(a) : 128'h0;
        end
    endtask

    task automatic fetch(input logic [31:0] addr, output logic [31:0] data, output int lat);
        int guard;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = addr;
        guard = 0;
        do begin cyc(); guard++; end while (!acc_last && guard < 40);
        bus.cpu_req_valid = 1'b0;
        lat   = 1;
        guard = 0;
        while (!bus.cpu_rsp_valid && guard < 40) begin cyc(); lat++; guard++; end
        if (!bus.cpu_rsp_valid) lat = -1;
        data = bus.cpu_rsp_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_addr  = '0;
        bus.flush         = 1'b0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        mem_auto = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
    endtask

    // Random cycle: the model tracks line residency per set, outstanding miss and deferred flush.
    task automatic rstep(input bit v, input logic [31:0] a, input bit f, input bit mrdy);
        bit         exp_hit;
        logic [3:0] idx;
        bus.cpu_req_valid = v;
        bus.cpu_req_addr  = a;
        bus.flush         = f;
        bus.mem_req_ready = mrdy;
        #2;
        chk("rnd_ready", 128'(bus.cpu_req_ready), 128'(!f && !outstanding && !gate));
        cyc();
        gate = 0;
        if (flush_last) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            if (outstanding) pend = 1;
        end
        if (acc_last) begin
            idx     = a[7:4];
            exp_hit = m_valid[idx] && (m_line[idx] == a[31:4]);
            if (exp_hit) begin
                m_hits++;
                chk("rnd_hit_vld", 128'(bus.cpu_rsp_valid), 128'(1));
                chk("rnd_hit_dat", 128'(bus.cpu_rsp_data), 128'(exp_word(a)));
            end else begin
                m_misses++;
                m_valid[idx] = 1;
                m_line[idx]  = a[31:4];
                outstanding  = 1;
                exp_miss     = exp_word(a);
                wait_cnt     = 0;
                chk("rnd_miss_early_rsp", 128'(bus.cpu_rsp_valid), 128'(0));
            end
        end else if (bus.cpu_rsp_valid) begin
            if (outstanding) begin
                chk("rnd_fill_dat", 128'(bus.cpu_rsp_data), 128'(exp_miss));
                outstanding = 0;
                if (pend) begin gate = 1; pend = 0; end
            end else begin
                chk("rnd_spurious_rsp", 128'(bus.cpu_rsp_valid), 128'(0));
            end
        end else if (outstanding) begin
            wait_cnt++;
            if (wait_cnt > 60) begin
                chk("rnd_fill_timeout", 128'(bus.cpu_rsp_valid), 128'(1));
                outstanding = 0;
                pend = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] d;
        int          lat, f0, bad_rsp;
        logic [31:0] pool_tag [4];

        vecs[0] = '{32'h0000_0100, 1, exp_word(32'h100)};
        vecs[1] = '{32'h0000_0200, 3, exp_word(32'h200)};
        vecs[2] = '{32'h0000_0100, 3, exp_word(32'h100)};
        vecs[3] = '{32'h0000_03C8, 3, exp_word(32'h3C8)};
        vecs[4] = '{32'h0000_03C4, 1, exp_word(32'h3C4)};
        vecs[5] = '{32'h0000_010C, 1, 32'h4444_4444};

        fills = 0;
        do_reset();
        #1;
        chk("rst_rsp_valid", 128'(bus.cpu_rsp_valid), 128'(0));
        chk("rst_rsp_data",  128'(bus.cpu_rsp_data),  128'(0));
        chk("rst_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        chk("rst_mem_addr",  128'(bus.mem_req_addr),  128'(0));
        chk("rst_hit_cnt",   128'(bus.hit_cnt),       128'(0));
        chk("rst_miss_cnt",  128'(bus.miss_cnt),      128'(0));
        chk("rst_ready",     128'(bus.cpu_req_ready), 128'(1));

        // Cold miss on line 0x10.
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h100;
        cyc();
        chk("cold_accept", 128'(acc_last), 128'(1));
        bus.cpu_req_valid = 1'b0;
        chk("cold_mem_valid", 128'(bus.mem_req_valid), 128'(1));
        chk("cold_mem_addr",  128'(bus.mem_req_addr),  128'(14'h10));
        cyc();
        chk("cold_no_rsp_n2", 128'(bus.cpu_rsp_valid), 128'(0));
        cyc();
        chk("cold_rsp_valid", 128'(bus.cpu_rsp_valid), 128'(1));
        chk("cold_rsp_data",  128'(bus.cpu_rsp_data),  128'(32'h1111_1111));
        chk("cold_ready_n3",  128'(bus.cpu_req_ready), 128'(1));
        chk("cold_miss_cnt",  128'(bus.miss_cnt),      128'(1));

        // Back-to-back hits on the rest of the line.
        f0 = fills;
        for (int i = 1; i < 4; i++) begin
            bus.cpu_req_valid = 1'b1;
            bus.cpu_req_addr  = 32'h100 + 32'(4 * i);
            cyc();
            chk("b2b_rsp_valid", 128'(bus.cpu_rsp_valid), 128'(1));
            chk("b2b_rsp_data",  128'(bus.cpu_rsp_data),  128'(exp_word(32'h100 + 32'(4 * i))));
            chk("b2b_no_mem_req", 128'(bus.mem_req_valid), 128'(0));
        end
        bus.cpu_req_valid = 1'b0;
        cyc();
        chk("hold_rsp_valid", 128'(bus.cpu_rsp_valid), 128'(0));
        chk("hold_rsp_data",  128'(bus.cpu_rsp_data),  128'(32'h4444_4444));
        chk("b2b_hit_cnt",    128'(bus.hit_cnt),       128'(3));
        chk("b2b_no_fill",    128'(fills - f0),        128'(0));

        // Vector table: hits, same-index conflicts and a second set.
        foreach (vecs[i]) begin
            fetch(vecs[i].addr, d, lat);
            chk($sformatf("vec%0d_lat", i),  128'(lat), 128'(vecs[i].lat));
            chk($sformatf("vec%0d_data", i), 128'(d),   128'(vecs[i].data));
        end
        chk("vec_hit_cnt",  128'(bus.hit_cnt),  128'(6));
        chk("vec_miss_cnt", 128'(bus.miss_cnt), 128'(4));

        // Memory stalls the request for 5 cycles.
        bus.mem_req_ready = 1'b0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h300;
        f0 = fills;
        cyc();
        chk("stall_accept", 128'(acc_last), 128'(1));
        bus.cpu_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_mem_valid", 128'(bus.mem_req_valid), 128'(1));
            chk("stall_mem_addr",  128'(bus.mem_req_addr),  128'(14'h30));
            chk("stall_cpu_ready", 128'(bus.cpu_req_ready), 128'(0));
            cyc();
        end
        bus.mem_req_ready = 1'b1;
        lat = 0;
        while (!bus.cpu_rsp_valid && lat < 40) begin cyc(); lat++; end
        chk("stall_rsp_lat",  128'(lat), 128'(2));
        chk("stall_rsp_data", 128'(bus.cpu_rsp_data), 128'(exp_word(32'h300)));
        repeat (3) cyc();
        chk("stall_single_fill", 128'(fills - f0), 128'(1));

        // Flush in RUN blocks the concurrent request; it is accepted next cycle as a miss.
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h100;
        bus.flush         = 1'b1;
        #2;
        chk("frun_ready", 128'(bus.cpu_req_ready), 128'(0));
        cyc();
        chk("frun_not_accepted", 128'(acc_last), 128'(0));
        bus.flush = 1'b0;
        fetch(32'h100, d, lat);
        chk("frun_first_cycle_accept", 128'(acc_last || lat == 3), 128'(1));
        chk("frun_miss_lat",  128'(lat), 128'(3));
        chk("frun_miss_data", 128'(d),   128'(32'h1111_1111));

        // Flush during MISS_WAIT: response still delivered, line not retained.
        mem_auto = 1'b0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h200;
        cyc();
        bus.cpu_req_valid = 1'b0;
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        cyc();
        chk("fwait_ready", 128'(bus.cpu_req_ready), 128'(0));
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = line_of(14'h20);
        cyc();
        bus.mem_rsp_valid = 1'b0;
        chk("fwait_rsp_valid", 128'(bus.cpu_rsp_valid), 128'(1));
        chk("fwait_rsp_data",  128'(bus.cpu_rsp_data),  128'(exp_word(32'h200)));
        chk("fwait_pend_ready", 128'(bus.cpu_req_ready), 128'(0));
        cyc();
        chk("fwait_ready_back", 128'(bus.cpu_req_ready), 128'(1));
        mem_auto = 1'b1;
        fetch(32'h200, d, lat);
        chk("fwait_refetch_lat", 128'(lat), 128'(3));
        chk("dir_hit_cnt",  128'(bus.hit_cnt),  128'(6));
        chk("dir_miss_cnt", 128'(bus.miss_cnt), 128'(8));

        // Reset during MISS_WAIT followed by a stale memory response.
        mem_auto = 1'b0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_addr  = 32'h104;
        cyc();
        bus.cpu_req_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("rmid_mem_valid", 128'(bus.mem_req_valid), 128'(0));
        chk("rmid_miss_cnt",  128'(bus.miss_cnt),      128'(0));
        cyc();
        rst = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = line_of(14'h10);
        cyc();
        bus.mem_rsp_valid = 1'b0;
        bad_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.cpu_rsp_valid) bad_rsp++;
            cyc();
        end
        chk("rmid_no_rsp",   128'(bad_rsp),      128'(0));
        chk("rmid_hit_cnt",  128'(bus.hit_cnt),  128'(0));
        chk("rmid_miss_cnt2", 128'(bus.miss_cnt), 128'(0));
        mem_auto = 1'b1;
        fetch(32'h200, d, lat);
        chk("rmid_invalid_lat", 128'(lat), 128'(3));
        fetch(32'h104, d, lat);
        chk("rmid_stale_dropped_lat", 128'(lat), 128'(3));
        chk("rmid_stale_data", 128'(d), 128'(32'h2222_2222));

        // Random traffic against the model.
        do_reset();
        foreach (m_valid[i]) m_valid[i] = 0;
        outstanding = 0; pend = 0; gate = 0;
        m_hits = 0; m_misses = 0; wait_cnt = 0;
        pool_tag[0] = 32'h0; pool_tag[1] = 32'h1; pool_tag[2] = 32'h2; pool_tag[3] = 32'h1_0000;
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            a = (pool_tag[$urandom_range(0, 3)] << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            rstep($urandom_range(0, 2) != 0, a, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
        end
        for (int n = 0; n < 100 && (outstanding || gate); n++) rstep(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rnd_drained",  128'(outstanding), 128'(0));
        chk("rnd_hit_cnt",  128'(bus.hit_cnt),  128'(m_hits));
        chk("rnd_miss_cnt", 128'(bus.miss_cnt), 128'(m_misses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
